// File: rtl/mult_seq.sv
// mult_seq: multi-cycle unsigned 32x32->32 shift-and-add multiplier driving the shared ALU
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, op_a, op_b  request and operands, sampled only when idle
//   busy               operation in progress, also selects this block's ALU controls
//   done               one-cycle completion pulse
//   product, ovf       low 32 bits of op_a*op_b and exact overflow, held until next start
//   alu_data1/2, alu_op, alu_flag_sel, alu_shamt, alu_is_log, alu_dir  ALU controls
//   alu_result, alu_flag  combinational ALU outputs
// Option: MULT_SEQ_EARLY_EXIT_EN finishes as soon as no multiplier bits remain.
module mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        ovf,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [2:0]  alu_op,
    output logic [2:0]  alu_flag_sel,
    output logic [4:0]  alu_shamt,
    output logic        alu_is_log,
    output logic        alu_dir,
    input  logic [31:0] alu_result,
    input  logic        alu_flag
);
    typedef enum logic [1:0] {IDLE, ADD, SHIFT} state_t;
    state_t      state;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  cnt;
    logic        last;
    // ADD: acc + mcand with carry flag; SHIFT: logical left shift of mcand by one
    always_comb begin
        alu_data1    = (state == ADD) ? acc : 32'd0;
        alu_data2    = (state == IDLE) ? 32'd0 : mcand;
        alu_op       = (state == SHIFT) ? 3'b100 : 3'b000;
        alu_flag_sel = (state == SHIFT) ? 3'b111 : 3'b000;
        alu_shamt    = (state == SHIFT) ? 5'd1 : 5'd0;
        alu_is_log   = (state == SHIFT);
        alu_dir      = (state == SHIFT);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        last         = (cnt == 6'd31) || (mplier[31:1] == 31'd0);
`else
        last         = (cnt == 6'd31);
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= 32'd0;
            mcand   <= 32'd0;
            mplier  <= 32'd0;
            cnt     <= 6'd0;
            product <= 32'd0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    acc     <= 32'd0;
                    mcand   <= op_a;
                    mplier  <= op_b;
                    cnt     <= 6'd0;
                    product <= 32'd0;
                    ovf     <= 1'b0;
                    busy    <= 1'b1;
                    state   <= ADD;
                end
                ADD: begin
                    if (mplier[0]) begin
                        acc <= alu_result;
                        ovf <= ovf | alu_flag;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    mcand  <= alu_result;
                    // a multiplicand bit shifted out is lost only if a later add would use it
                    ovf    <= ovf | (mcand[31] & (mplier[31:1] != 31'd0));
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (last) begin
                        product <= acc;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= ADD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: scoreboard bench for mult_seq with a behavioural model of the shared ALU
module tb_mult_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        ovf;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [2:0]  alu_op;
    logic [2:0]  alu_flag_sel;
    logic [4:0]  alu_shamt;
    logic        alu_is_log;
    logic        alu_dir;
    logic [31:0] alu_result;
    logic        alu_flag;
    logic [32:0] alu_sum;

    mult_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product), .ovf(ovf),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_flag_sel(alu_flag_sel), .alu_shamt(alu_shamt), .alu_is_log(alu_is_log),
        .alu_dir(alu_dir), .alu_result(alu_result), .alu_flag(alu_flag)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_sum    = {1'b0, alu_data1} + {1'b0, alu_data2};
        alu_result = (alu_op == 3'b100) ? (alu_dir ? (alu_data2 << alu_shamt) : (alu_data2 >> alu_shamt))
                                        : alu_sum[31:0];
        alu_flag   = (alu_flag_sel == 3'b000) ? alu_sum[32] : 1'b0;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic        o;
        int          lat;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    function automatic int exp_lat(input logic [31:0] b);
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) if (b[i]) m = i + 1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
        return (m == 0) ? 2 : 2 * m;
`else
        return 64;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_flags"}, {61'd0, busy, done, ovf}, 64'd0);
        chk({tag, "_product"}, {32'd0, product}, 64'd0);
        chk({tag, "_alu_data"}, {alu_data1, alu_data2}, 64'd0);
        chk({tag, "_alu_ctl"}, {51'd0, alu_op, alu_flag_sel, alu_shamt, alu_is_log, alu_dir}, 64'd0);
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] full;
        full  = {32'd0, a} * {32'd0, b};
        e.a   = a;
        e.b   = b;
        e.p   = full[31:0];
        e.o   = |full[63:32];
        e.lat = exp_lat(b);
        q.push_back(e);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
    endtask

    // Called at the negedge where start is driven; returns at the negedge of the done cycle.
    task automatic wait_done(input bit hold, input logic [31:0] na, input logic [31:0] nb);
        int k;
        int busy_low;
        exp_t e;
        k = 0;
        busy_low = 0;
        e = q[0];
        @(negedge clk);
        if (hold) begin
            op_a = na;
            op_b = nb;
        end else begin
            start = 1'b0;
        end
        while (!done && k < 200) begin
            if (!busy) busy_low++;
            if (k == 0) begin
                chk("add_alu_data", {alu_data1, alu_data2}, {32'd0, e.a});
                chk("add_alu_ctl", {51'd0, alu_op, alu_flag_sel, alu_shamt, alu_is_log, alu_dir}, 64'd0);
            end
            if (k == 1)
                chk("shift_alu_ctl", {51'd0, alu_op, alu_flag_sel, alu_shamt, alu_is_log, alu_dir},
                    {51'd0, 3'b100, 3'b111, 5'd1, 1'b1, 1'b1});
            @(negedge clk);
            k++;
        end
        e = q.pop_front();
        chk("latency", 64'(k), 64'(e.lat));
        chk("product", {32'd0, product}, {32'd0, e.p});
        chk("ovf", {63'd0, ovf}, {63'd0, e.o});
        chk("busy_low_during_op", 64'(busy_low), 64'd0);
        chk("busy_in_done_cycle", {63'd0, busy}, 64'd0);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        launch(a, b);
        wait_done(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int dn;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        run(32'd7, 32'd6);
        repeat (3) @(negedge clk);
        chk("product_held", {32'd0, product}, 64'd42);
        run(32'hFFFF_FFFF, 32'd1);
        run(32'h0001_0000, 32'h0001_0000);
        run(32'h8000_0001, 32'd2);
        run(32'h1234_5678, 32'h0000_9ABC);

        // abort mid-operation with an asynchronous reset
        @(negedge clk);
        launch(32'd3, 32'd5);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle("abort");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        dn = 0;
        repeat (80) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("no_done_after_abort", 64'(dn), 64'd0);
        chk_idle("after_abort");

        // start held through busy with changing operands is ignored; the done-cycle start is taken
        @(negedge clk);
        launch(32'd3, 32'd5);
        wait_done(1'b1, 32'd9, 32'd9);
        launch(32'd9, 32'd9);
        wait_done(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("done_one_cycle_b2b", {63'd0, done}, 64'd0);

        run(32'd1, 32'd1);
        run(32'd5, 32'd0);
        run(32'd1, 32'h8000_0000);
        run(32'd3, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
